// File: rtl/engine_response_merger_pkg.sv
// Memory/engine packet types shared by the response merger and its users.
// Holds the packet structs, the merge state encoding and the helper that
// folds one memory response into an engine packet's data fields.
package PKG_MEMORY;

    localparam int ENGINE_PACKET_DATA_NUM_FIELDS = 4;
    localparam int DATA_W                        = 32;
    localparam int MERGE_COUNT_W                 = $clog2(ENGINE_PACKET_DATA_NUM_FIELDS) + 1;

    typedef enum logic [1:0] {
        CMD_INVALID      = 2'd0,
        CMD_MEM_READ     = 2'd1,
        CMD_MEM_RESPONSE = 2'd2,
        CMD_ENGINE_DATA  = 2'd3
    } type_memory_cmd;

    typedef struct packed {
        logic [3:0] id_bundle;
        logic [3:0] id_lane;
    } PacketRouteAddress;

    typedef struct packed {
        PacketRouteAddress packet_source;
        PacketRouteAddress packet_destination;
    } PacketRoute;

    typedef struct packed {
        type_memory_cmd cmd;
    } PacketSubclass;

    typedef struct packed {
        PacketRoute    route;
        PacketSubclass subclass;
    } PacketMeta;

    typedef struct packed {
        logic [ENGINE_PACKET_DATA_NUM_FIELDS-1:0][DATA_W-1:0] field;
    } EnginePacketData;

    typedef struct packed {
        PacketMeta       meta;
        EnginePacketData data;
    } EnginePacketPayload;

    typedef struct packed {
        logic               valid;
        EnginePacketPayload payload;
    } EnginePacket;

    typedef struct packed {
        logic [DATA_W-1:0] field;
    } MemoryResponsePacketData;

    typedef struct packed {
        PacketMeta               meta;
        MemoryResponsePacketData data;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacket;

    typedef enum logic [2:0] {
        MERGE_IDLE    = 3'b001,
        MERGE_COLLECT = 3'b010,
        MERGE_EMIT    = 3'b100
    } type_response_merge_state;

    // Newest response lands in field[0]; older fields slide up by one slot.
    function automatic EnginePacketData map_MemoryResponsePacketData_to_EnginePacketData(
        input MemoryResponsePacketData response,
        input EnginePacketData         current
    );
        EnginePacketData merged;
        merged.field = {current.field[ENGINE_PACKET_DATA_NUM_FIELDS-2:0], response.field};
        return merged;
    endfunction

endpackage

// File: rtl/engine_response_merger.sv
// Merges FIELDS_REQUIRED memory read responses into a pending engine packet
// template and emits the result as one engine packet.
// Optional source-id checking is compiled in with GRAPHBLOX_RESPONSE_ID_CHECK_EN.
module engine_response_merger
    import PKG_MEMORY::*;
#(
    parameter int FIELDS_REQUIRED = 1,
    parameter int ID_CHECK_SOURCE = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  EnginePacket              template_in,
    output logic                     template_in_ready,
    input  MemoryPacket              response_in,
    output logic                     response_in_ready,
    output EnginePacket              engine_out,
    input  logic                     engine_out_ready,
    output logic [MERGE_COUNT_W-1:0] merge_count_out,
    output logic                     error_out
);

    localparam logic [MERGE_COUNT_W-1:0] LAST_COUNT = MERGE_COUNT_W'(FIELDS_REQUIRED - 1);

    type_response_merge_state state;
    type_response_merge_state next_state;
    PacketRoute               template_route;
    EnginePacketData          merge_data;
    logic [MERGE_COUNT_W-1:0] count;
    logic                     error_q;
    logic                     response_take;
    logic                     response_bad;
    logic                     response_merge;
    logic                     unused_fields;

    assign response_take = (state == MERGE_COLLECT) && response_in.valid;

`ifdef GRAPHBLOX_RESPONSE_ID_CHECK_EN
    assign response_bad  = (ID_CHECK_SOURCE != 0) &&
                           (response_in.payload.meta.route.packet_source != template_route.packet_source);
    assign unused_fields = ^{response_in.payload.meta.route.packet_destination,
                             response_in.payload.meta.subclass,
                             template_in.payload.meta.subclass};
`else
    assign response_bad  = 1'b0;
    assign unused_fields = ^{response_in.payload.meta,
                             template_in.payload.meta.subclass,
                             (ID_CHECK_SOURCE != 0)};
`endif

    assign response_merge  = response_take && !response_bad;
    assign merge_count_out = count;
    assign error_out       = error_q;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= MERGE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Template latch, response merge, count and reject pulse.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            template_route <= '0;
            merge_data     <= '0;
            count          <= '0;
            error_q        <= 1'b0;
        end else begin
            error_q <= response_take && response_bad;
            if (state == MERGE_IDLE && template_in.valid) begin
                template_route <= template_in.payload.meta.route;
                merge_data     <= template_in.payload.data;
                count          <= '0;
            end
            if (response_merge) begin
                merge_data <= map_MemoryResponsePacketData_to_EnginePacketData(
                                  response_in.payload.data, merge_data);
                count      <= count + MERGE_COUNT_W'(1);
            end
        end
    end

    // Next state, handshake readies and the emitted packet.
    always_comb begin
        next_state        = state;
        template_in_ready = 1'b0;
        response_in_ready = 1'b0;
        engine_out        = '0;
        unique case (state)
            MERGE_IDLE: begin
                // Readies are held low while reset is asserted.
                template_in_ready = ap_rst_n;
                if (template_in.valid) begin
                    next_state = MERGE_COLLECT;
                end
            end
            MERGE_COLLECT: begin
                response_in_ready = ap_rst_n;
                if (response_merge && count == LAST_COUNT) begin
                    next_state = MERGE_EMIT;
                end
            end
            MERGE_EMIT: begin
                engine_out.valid                      = 1'b1;
                engine_out.payload.meta.route         = template_route;
                engine_out.payload.meta.subclass.cmd  = CMD_ENGINE_DATA;
                engine_out.payload.data               = merge_data;
                if (engine_out_ready) begin
                    next_state = MERGE_IDLE;
                end
            end
            default: begin
                next_state = MERGE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_engine_response_merger.sv
// Self-checking bench for engine_response_merger: a FIELDS_REQUIRED=1 instance
// for the single-response case and a FIELDS_REQUIRED=3 instance driven with
// random templates/responses against a queue-based reference model.
module tb_engine_response_merger;
    import PKG_MEMORY::*;

`ifdef GRAPHBLOX_RESPONSE_ID_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    EnginePacket              t1, t3, o1, o3;
    MemoryPacket              r1, r3;
    logic                     t1_rdy, t3_rdy, r1_rdy, r3_rdy, o1_rdy, o3_rdy;
    logic [MERGE_COUNT_W-1:0] c1, c3;
    logic                     e1, e3;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] acc_q[$];

    engine_response_merger #(.FIELDS_REQUIRED(1), .ID_CHECK_SOURCE(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .template_in(t1), .template_in_ready(t1_rdy),
        .response_in(r1), .response_in_ready(r1_rdy),
        .engine_out(o1), .engine_out_ready(o1_rdy),
        .merge_count_out(c1), .error_out(e1)
    );

    engine_response_merger #(.FIELDS_REQUIRED(3), .ID_CHECK_SOURCE(1)) dut3 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .template_in(t3), .template_in_ready(t3_rdy),
        .response_in(r3), .response_in_ready(r3_rdy),
        .engine_out(o3), .engine_out_ready(o3_rdy),
        .merge_count_out(c3), .error_out(e3)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected packet: the n accepted responses, newest first, followed by the
    // template's own fields moved up by n slots.
    function automatic EnginePacket expect_pkt(input EnginePacket tpl);
        EnginePacket e;
        int n;
        n = acc_q.size();
        e = '0;
        e.valid = 1'b1;
        e.payload.meta = tpl.payload.meta;
        e.payload.meta.subclass.cmd = CMD_ENGINE_DATA;
        for (int i = 0; i < ENGINE_PACKET_DATA_NUM_FIELDS; i++) begin
            if (i < n) e.payload.data.field[i] = acc_q[n-1-i];
            else       e.payload.data.field[i] = tpl.payload.data.field[i-n];
        end
        return e;
    endfunction

    function automatic EnginePacket rand_tpl();
        EnginePacket t;
        t = '0;
        t.valid = 1'b1;
        t.payload.meta.route.packet_source      = 8'($urandom);
        t.payload.meta.route.packet_destination = 8'($urandom);
        t.payload.meta.subclass.cmd = type_memory_cmd'(2'($urandom_range(0, 2)));
        for (int i = 0; i < ENGINE_PACKET_DATA_NUM_FIELDS; i++) begin
            t.payload.data.field[i] = $urandom;
        end
        return t;
    endfunction

    // One full packet through dut3 (FIELDS_REQUIRED=3).
    task automatic run_packet(input int stall, input bit collide, input bit allow_bad);
        EnginePacket tpl, ghost, exp;
        MemoryPacket r;
        bit bad, exp_err;
        int guard;
        tpl = rand_tpl();
        acc_q.delete();
        guard = 0;
        while (!t3_rdy && guard < 20) begin
            tick();
            guard++;
        end
        check("tpl_ready", t3_rdy, 1);
        t3 = tpl;
        if (collide) begin
            r3 = '0;
            r3.valid = 1'b1;
            r3.payload.data.field = $urandom;
            r3.payload.meta.route.packet_source = tpl.payload.meta.route.packet_source;
            check("collide_resp_ready", r3_rdy, 0);
        end
        tick();
        t3 = '0;
        r3 = '0;
        check("count_clear", c3, 0);
        guard = 0;
        while (acc_q.size() < 3 && guard < 200) begin
            r = '0;
            r.valid = ($urandom_range(0, 2) != 0);
            r.payload.data.field = $urandom;
            r.payload.meta.route.packet_source      = tpl.payload.meta.route.packet_source;
            r.payload.meta.route.packet_destination = 8'($urandom);
            r.payload.meta.subclass.cmd = CMD_MEM_RESPONSE;
            bad = 1'b0;
            if (allow_bad && $urandom_range(0, 3) == 0) begin
                r.payload.meta.route.packet_source.id_bundle =
                    tpl.payload.meta.route.packet_source.id_bundle + 4'd1;
                bad = 1'b1;
            end
            check("collect_resp_ready", r3_rdy, 1);
            check("collect_no_output", o3.valid, 0);
            r3 = r;
            tick();
            exp_err = CHECK && r.valid && bad;
            if (r.valid && !exp_err) acc_q.push_back(r.payload.data.field);
            check("error_pulse", e3, exp_err);
            check("count_step", c3, acc_q.size());
            guard++;
        end
        r3 = '0;
        check("collect_bound", guard < 200, 1);
        exp = expect_pkt(tpl);
        ghost = rand_tpl();
        for (int s = 0; s <= stall; s++) begin
            check("emit_payload", o3, exp);
            check("emit_count", c3, 3);
            check("emit_tpl_ready", t3_rdy, 0);
            check("emit_resp_ready", r3_rdy, 0);
            t3 = (s < stall) ? ghost : '0;
            o3_rdy = (s == stall);
            tick();
        end
        o3_rdy = 1'b0;
        t3 = '0;
        check("after_handshake_valid", o3.valid, 0);
        check("after_handshake_tpl_ready", t3_rdy, 1);
        check("after_handshake_count", c3, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        EnginePacket tpl;
        ap_rst_n = 1'b0;
        t1 = '0; t3 = '0; r1 = '0; r3 = '0;
        o1_rdy = 1'b0; o3_rdy = 1'b0;
        repeat (3) tick();
        check("rst_out3", o3, 0);
        check("rst_cnt3", c3, 0);
        check("rst_err3", e3, 0);
        check("rst_tpl_ready3", t3_rdy, 0);
        check("rst_resp_ready3", r3_rdy, 0);
        check("rst_out1", o1, 0);
        check("rst_tpl_ready1", t1_rdy, 0);
        ap_rst_n = 1'b1;
        tick();
        check("post_rst_tpl_ready3", t3_rdy, 1);
        check("post_rst_tpl_ready1", t1_rdy, 1);

        // Single-response merge.
        t1 = '0;
        t1.valid = 1'b1;
        t1.payload.meta.route.packet_source = 8'h21;
        t1.payload.meta.subclass.cmd = CMD_MEM_READ;
        t1.payload.data.field[0] = 32'hA;
        tick();
        t1 = '0;
        check("fr1_resp_ready", r1_rdy, 1);
        check("fr1_count_clear", c1, 0);
        r1 = '0;
        r1.valid = 1'b1;
        r1.payload.meta.route.packet_source = 8'h21;
        r1.payload.data.field = 32'h55;
        tick();
        r1 = '0;
        check("fr1_valid", o1.valid, 1);
        check("fr1_field0", o1.payload.data.field[0], 32'h55);
        check("fr1_field1", o1.payload.data.field[1], 32'hA);
        check("fr1_field2", o1.payload.data.field[2], 0);
        check("fr1_cmd", o1.payload.meta.subclass.cmd, CMD_ENGINE_DATA);
        check("fr1_src", o1.payload.meta.route.packet_source, 8'h21);
        check("fr1_count", c1, 1);
        o1_rdy = 1'b1;
        tick();
        o1_rdy = 1'b0;
        check("fr1_done", o1.valid, 0);
        check("fr1_tpl_ready", t1_rdy, 1);

        // Plain packet, stalled output, template/response collision.
        run_packet(0, 1'b0, 1'b0);
        run_packet(5, 1'b0, 1'b0);
        run_packet(0, 1'b1, 1'b0);

        // Reset after one accepted response discards the partial packet.
        tpl = rand_tpl();
        t3 = tpl;
        tick();
        t3 = '0;
        r3 = '0;
        r3.valid = 1'b1;
        r3.payload.meta.route.packet_source = tpl.payload.meta.route.packet_source;
        r3.payload.data.field = 32'hDEAD_0001;
        tick();
        check("mid_count", c3, 1);
        ap_rst_n = 1'b0;
        tick();
        check("midrst_out", o3, 0);
        check("midrst_cnt", c3, 0);
        check("midrst_err", e3, 0);
        check("midrst_tpl_ready", t3_rdy, 0);
        check("midrst_resp_ready", r3_rdy, 0);
        r3 = '0;
        ap_rst_n = 1'b1;
        tick();
        check("midrst_release_ready", t3_rdy, 1);
        tick();
        check("midrst_no_output", o3.valid, 0);
        run_packet(0, 1'b0, 1'b0);

        // Random traffic, including mismatched-source responses.
        for (int k = 0; k < 20; k++) begin
            run_packet($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/engine_response_merger.md
ENGINE_RESPONSE_MERGER -- requirements
Module: engine_response_merger

Interface
REQ-001 Parameter FIELDS_REQUIRED, default 1, meaning: number of memory responses merged per engine packet; legal range 1..ENGINE_PACKET_DATA_NUM_FIELDS.
REQ-002 Parameter ID_CHECK_SOURCE, default 1, meaning: 1 = compare response packet_source against the template; only effective when the check feature is compiled in.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 ap_clk  in  1  clock; all state updates on its rising edge.
REQ-005 ap_rst_n  in  1  synchronous active-low reset.
REQ-006 template_in  in  EnginePacket  pending engine packet (meta plus initial data) awaiting read data.
REQ-007 template_in_ready  out  1  high while the block can accept a template.
REQ-008 response_in  in  MemoryPacket  memory read response.
REQ-009 response_in_ready  out  1  high while the block can accept a response.
REQ-010 engine_out  out  EnginePacket  merged engine packet.
REQ-011 engine_out_ready  in  1  downstream accepts engine_out.
REQ-012 merge_count_out  out  clog2(ENGINE_PACKET_DATA_NUM_FIELDS)+1  responses merged into the current packet.
REQ-013 error_out  out  1  one-cycle pulse when a response is rejected.

Function
REQ-014 FSM states: IDLE, COLLECT, EMIT; one-hot encoded.
REQ-015 IDLE: template_in_ready=1; a template is accepted when template_in.valid=1; the payload is latched and count cleared; next state is COLLECT.
REQ-016 COLLECT: response_in_ready=1; a response is accepted when response_in.valid=1.
REQ-017 On an accepted response, the data is updated as: field[0] = response field, field[i] = previous field[i-1] for i>=1; count increments by 1.
REQ-018 When count reaches FIELDS_REQUIRED on an accept, the next state is EMIT; engine_out.valid rises the cycle after the last accepted response.
REQ-019 EMIT: engine_out.valid=1 and the payload is held stable until engine_out_ready=1; in that cycle the next state is IDLE.
REQ-020 engine_out.payload.meta equals the latched template meta, with subclass.cmd forced to CMD_ENGINE_DATA.
REQ-021 template_in is ignored outside IDLE, and response_in is ignored outside COLLECT; the corresponding ready is 0.
REQ-022 A response whose valid field is 0 is never counted, even when response_in_ready=1.
REQ-023 Back-to-back packets: minimum occupancy per packet is 1 + FIELDS_REQUIRED + 1 cycles (IDLE, COLLECT, EMIT).
REQ-024 Count never exceeds FIELDS_REQUIRED; no wrap-around is possible.

Reset
REQ-025 While ap_rst_n=0 at a clock edge: state=IDLE, count=0, engine_out=0 (valid=0), error_out=0, template_in_ready=0, response_in_ready=0.
REQ-026 Reset asserted mid-COLLECT or mid-EMIT discards the partial packet; no engine_out.valid is produced after reset deassertion until a new template completes.
REQ-027 template_in_ready returns to 1 on the first cycle after reset deassertion.

Configuration
REQ-028 Macro GRAPHBLOX_RESPONSE_ID_CHECK_EN defined, with ID_CHECK_SOURCE=1: a response whose meta.route.packet_source differs from the template's packet_source is consumed (ready=1), not merged and not counted, and error_out pulses for 1 cycle.
REQ-029 Macro GRAPHBLOX_RESPONSE_ID_CHECK_EN undefined: every valid response is merged, and error_out is constant 0.

Structure
REQ-030 The FSM state enum type_response_merge_state belongs in PKG_MEMORY.
REQ-031 The merge uses the existing PKG_MEMORY function map_MemoryResponsePacketData_to_EnginePacketData; the shift logic is not duplicated.
REQ-032 The block is a single module with no sub-module; input buffering is the instantiating engine's responsibility.

Verification
REQ-033 FIELDS_REQUIRED=1; template data {0,0,0,0xA}; one response 0x55 -> engine_out.valid one cycle after accept, field[0]=0x55, field[1]=0xA, cmd=CMD_ENGINE_DATA.
REQ-034 FIELDS_REQUIRED=3; responses 0x1, 0x2, 0x3 with gaps of 2 idle cycles -> field[0..2]={0x3,0x2,0x1}, merge_count_out=3, exactly one output.
REQ-035 engine_out_ready held 0 for 5 cycles in EMIT -> payload stable for all 5 cycles, template_in_ready=0, and a new template is accepted only after the handshake.
REQ-036 Check macro defined; template source id_bundle=2; response with id_bundle=1 -> error_out pulses once, count unchanged; a following response with id_bundle=2 is merged.
REQ-037 ap_rst_n=0 after 1 of 3 responses -> all outputs 0; after a fresh template and 3 responses, output contains only the new data.
REQ-038 Simultaneous template_in.valid and response_in.valid in IDLE -> the template is accepted and the response is not consumed (response_in_ready=0).
